spi_loader: RTL and testbench

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/spi_loader_pkg.sv | 19 +
 rtl/spi_loader_sync.sv | 25 ++
 rtl/spi_loader.sv | 103 ++++++++++
 tb/tb_spi_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg: FSM encodings, header field positions and reset defaults shared by the SPI loader
`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif
package spi_loader_pkg;
    localparam int DATAPATH_W_DEF = `DATAPATH_W;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;
    localparam int HDR_TGT_BIT = 4;
    localparam int HDR_RSV_LSB = 5;
    localparam int HDR_RSV_MSB = 7;
    localparam logic   SYNC_RST  = 1'b1;
    localparam state_e STATE_RST = ST_DRAIN;
endpackage

// File: rtl/spi_loader_sync.sv
// spi_loader_sync: 2-flop synchronizer with rising-edge detect; resets to the idle-high level
module spi_loader_sync
    import spi_loader_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);
    logic meta_q, sync_q, prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= SYNC_RST;
            sync_q <= SYNC_RST;
            prev_q <= SYNC_RST;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/spi_loader.sv
// spi_loader: SPI frame receiver writing header-addressed bytes into icache/dcache; SPI_LOADER_AUTOINC_EN allows multi-byte frames
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int DATAPATH_W = DATAPATH_W_DEF,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  mosi_in,
    input  logic                  cs_n_in,
    output logic                  wr_en_out,
    output logic                  wr_target_out,
    output logic [ADDR_W-1:0]     wr_addr_out,
    output logic [DATAPATH_W-1:0] wr_data_out,
    output logic                  busy_out,
    output logic                  err_out
);
`ifdef SPI_LOADER_AUTOINC_EN
    localparam bit ONE_BYTE = 1'b0;
`else
    localparam bit ONE_BYTE = 1'b1;
`endif
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_nx;
    logic [DATAPATH_W-1:0] shift_q, shift_d, rx_byte, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]     addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic                  target_q, target_d, wr_target_q, wr_target_d;
    logic                  wr_en_q, wr_en_d, err_q, err_d, one_q, one_d;
    logic                  sclk_rise, mosi_s, cs_s, cs_rise, sclk_s_unused, mosi_rise_unused;
    logic                  in_frame, sample, done, hdr_ok, hdr_take, overrun, wr_fire;
    spi_loader_sync u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk_in), .q_o(sclk_s_unused), .rise_o(sclk_rise));
    spi_loader_sync u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi_in), .q_o(mosi_s), .rise_o(mosi_rise_unused));
    spi_loader_sync u_sync_cs   (.clk(clk), .rst(rst), .d_i(cs_n_in), .q_o(cs_s), .rise_o(cs_rise));
    assign in_frame = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign sample   = sclk_rise && in_frame;
    assign cnt_nx   = bit_cnt_q + CNT_W'(sample);
    assign done     = sample && (bit_cnt_q == '1);
    assign rx_byte  = {shift_q[DATAPATH_W-2:0], mosi_s};
    assign hdr_ok   = rx_byte[HDR_RSV_MSB:HDR_RSV_LSB] == '0;
    assign hdr_take = (state_q == ST_HDR) && done && hdr_ok;
    // Without auto-increment, the first bit after the single data byte is an overrun
    assign overrun  = ONE_BYTE && one_q && sample && (state_q == ST_DATA);
    assign wr_fire  = (state_q == ST_DATA) && done && !overrun;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_RST;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            target_q    <= 1'b0;
            one_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_target_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            target_q    <= target_d;
            one_q       <= one_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_target_q <= wr_target_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = cs_s ? ST_IDLE : ST_HDR;
            ST_HDR:  state_d = done ? (!hdr_ok ? ST_DRAIN : cs_rise ? ST_IDLE : ST_DATA)
                                    : (cs_rise ? ST_IDLE : ST_HDR);
            ST_DATA: state_d = overrun ? ST_DRAIN : cs_rise ? ST_IDLE : ST_DATA;
            default: state_d = cs_s ? ST_IDLE : ST_DRAIN;
        endcase
    end
    always_comb begin
        bit_cnt_d   = (state_q == ST_IDLE) ? '0 : cnt_nx;
        shift_d     = sample ? rx_byte : shift_q;
        addr_d      = hdr_take ? rx_byte[ADDR_W-1:0] : wr_fire ? addr_q + 1'b1 : addr_q;
        target_d    = hdr_take ? rx_byte[HDR_TGT_BIT] : target_q;
        one_d       = (state_q == ST_IDLE) ? 1'b0 : (one_q | wr_fire);
        err_d       = (state_q == ST_IDLE && !cs_s) ? 1'b0
                    : err_q | ((state_q == ST_HDR) && done && !hdr_ok) | overrun
                      | (in_frame && cs_rise && cnt_nx != '0);
        wr_en_d     = wr_fire;
        wr_target_d = wr_fire ? target_q : wr_target_q;
        wr_addr_d   = wr_fire ? addr_q : wr_addr_q;
        wr_data_d   = wr_fire ? rx_byte : wr_data_q;
    end
    assign wr_en_out     = wr_en_q;
    assign wr_target_out = wr_target_q;
    assign wr_addr_out   = wr_addr_q;
    assign wr_data_out   = wr_data_q;
    assign busy_out      = state_q != ST_IDLE;
    assign err_out       = err_q;
endmodule

// File: tb/tb_spi_loader.sv
// tb_spi_loader: scoreboard bench for spi_loader; expectations follow SPI_LOADER_AUTOINC_EN when defined
module tb_spi_loader;
    logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic       wr_en, wr_target, busy, err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [13:0] sb_q[$];
    int n_cmp = 0, n_bad = 0;

    spi_loader dut (
        .clk(clk), .rst(rst), .sclk_in(sclk), .mosi_in(mosi), .cs_n_in(cs_n),
        .wr_en_out(wr_en), .wr_target_out(wr_target), .wr_addr_out(wr_addr),
        .wr_data_out(wr_data), .busy_out(busy), .err_out(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit end_cs = 1'b0);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_clk(4);
            sclk = 1'b1;
            if (end_cs && i == 8 - n) cs_n = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic expect_wr(input logic t, input logic [3:0] a, input logic [7:0] d);
        sb_q.push_back({1'b1, t, a, d});
    endtask

    task automatic sb_drained(input string tag);
        chk(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Every strobe must match the oldest pending expectation; an empty queue expects no strobe
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            logic [13:0] e;
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 14'd0;
            chk("write", {18'd0, wr_en, wr_target, wr_addr, wr_data}, {18'd0, e});
        end
    end

    initial begin
        wait_clk(3);
        chk("rst_busy", busy, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_outs", {wr_target, wr_addr, wr_data}, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        chk("busy_after_rst", busy, 1);
        wait_clk(2);
        chk("idle_busy", busy, 0);

        frame_start();
        expect_wr(1'b0, 4'd3, 8'hA5);
        send_bits(8'h03, 8);
        send_bits(8'hA5, 8);
        frame_end();
        sb_drained("basic_writes");
        chk("basic_err", err, 0);
        chk("hold_data", wr_data, 8'hA5);
        chk("hold_addr", wr_addr, 4'd3);

        frame_start();
        expect_wr(1'b1, 4'd14, 8'h11);
`ifdef SPI_LOADER_AUTOINC_EN
        expect_wr(1'b1, 4'd15, 8'h22);
        expect_wr(1'b1, 4'd0, 8'h33);
`endif
        send_bits(8'h1E, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        frame_end();
        sb_drained("multi_writes");
`ifdef SPI_LOADER_AUTOINC_EN
        chk("multi_err", err, 0);
`else
        chk("multi_err", err, 1);
`endif
        chk("multi_target_hold", wr_target, 1);

        frame_start();
        send_bits(8'h83, 8);
        send_bits(8'h44, 8);
        wait_clk(4);
        chk("badhdr_err", err, 1);
        chk("badhdr_busy", busy, 1);
        frame_end();
        chk("badhdr_idle", busy, 0);
        sb_drained("badhdr_writes");
        frame_start();
        chk("err_cleared", err, 0);
        expect_wr(1'b0, 4'd5, 8'h5A);
        send_bits(8'h05, 8);
        send_bits(8'h5A, 8);
        frame_end();
        sb_drained("after_bad_writes");
        chk("after_bad_err", err, 0);

        frame_start();
        expect_wr(1'b0, 4'd1, 8'hC3);
        send_bits(8'h01, 8);
        send_bits(8'hC3, 8);
        send_bits(8'hFF, 5);
        frame_end();
        sb_drained("partial_writes");
        chk("partial_err", err, 1);
        chk("partial_idle", busy, 0);

        frame_start();
        send_bits(8'h00, 3);
        frame_end();
        chk("hdr_partial_err", err, 1);
        sb_drained("hdr_partial_writes");

        frame_start();
        send_bits(8'h07, 8);
        send_bits(8'hE0, 3);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        chk("midrst_busy", busy, 1);
        chk("midrst_err", err, 0);
        send_bits(8'hFF, 8);
        chk("drain_busy", busy, 1);
        frame_end();
        chk("drain_exit", busy, 0);
        sb_drained("midrst_writes");
        frame_start();
        expect_wr(1'b0, 4'd9, 8'h3C);
        send_bits(8'h09, 8);
        send_bits(8'h3C, 8);
        frame_end();
        sb_drained("post_rst_writes");

        frame_start();
        expect_wr(1'b0, 4'd2, 8'h55);
`ifdef SPI_LOADER_AUTOINC_EN
        expect_wr(1'b0, 4'd3, 8'h66);
`endif
        send_bits(8'h02, 8);
        send_bits(8'h55, 8);
        send_bits(8'h66, 1);
        wait_clk(4);
`ifdef SPI_LOADER_AUTOINC_EN
        chk("ninth_bit_err", err, 0);
`else
        chk("ninth_bit_err", err, 1);
        chk("ninth_bit_drain", busy, 1);
`endif
        send_bits(8'hCC, 7);
        frame_end();
        sb_drained("single_byte_writes");

        frame_start();
        expect_wr(1'b0, 4'd10, 8'h99);
        send_bits(8'h0A, 8);
        send_bits(8'h99, 8, 1'b1);
        wait_clk(12);
        sclk = 1'b0;
        wait_clk(4);
        sb_drained("simul_writes");
        chk("simul_err", err, 0);
        chk("simul_idle", busy, 0);

        for (int k = 0; k < 4; k++) begin
            logic [3:0] a;
            logic       t;
            logic [7:0] d;
            a = 4'($urandom_range(0, 15));
            t = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            frame_start();
            expect_wr(t, a, d);
            send_bits({3'b000, t, a}, 8);
            send_bits(d, 8);
            frame_end();
            sb_drained("rand_writes");
            chk("rand_err", err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
